fp_add_norm_sequencer: RTL and testbench

Parametrised control sequencer for the multi-cycle floating-point adder datapath. It replaces the fixed single-shot alignment/normalisation controller. It accepts an operation via a Go/Ready handshake and aligns the smaller operand in bounded per-cycle shift steps. It then normalises the sum right or left using the leading-one index from the FFO, rounds and renormalises, and reports completion with Done plus overflow, underflow and zero status flags. It sits between the exponent-difference/FFO/rounding logic and the shifter, exponent and mux controls of the datapath.

---
 rtl/fp_add_norm_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_fp_add_norm_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_norm_sequencer.sv
// Control sequencer for the multi-cycle FP adder: bounded-step alignment, normalisation, rounding.
// Build option FP_ADD_ROUND_EN enables the ROUND/RENORM states; without it results are truncated.
module fp_add_norm_sequencer #(
  parameter int EXPBITS      = 8,
  parameter int MANTISSABITS = 23,
  parameter int SHIFTSTEP    = 8,
  localparam int SW          = $clog2(MANTISSABITS + 3)
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Go,
  input  logic [EXPBITS-1:0] ExpA,
  input  logic [EXPBITS-1:0] ExpB,
  input  logic [EXPBITS-1:0] ExpCur,
  input  logic               FFOValid,
  input  logic [SW-1:0]      FFOIndex,
  input  logic               RoundCarry,
  output logic               Ready,
  output logic               Done,
  output logic               AlignEn,
  output logic               AlignSelB,
  output logic [SW-1:0]      AlignAmt,
  output logic               SREn,
  output logic               SLEn,
  output logic [SW-1:0]      ShiftAmount,
  output logic               IncrEn,
  output logic               DecrEn,
  output logic               RoundEn,
  output logic               Overflow,
  output logic               Underflow,
  output logic               Zero,
  output logic [2:0]         StateDbg
);

  localparam int CIDX  = MANTISSABITS + 2;
  localparam int HIDX  = MANTISSABITS + 1;
  localparam int MAXAL = MANTISSABITS + 2;

  localparam logic [SW-1:0]      CIDX_W  = SW'(CIDX);
  localparam logic [SW-1:0]      HIDX_W  = SW'(HIDX);
  localparam logic [SW-1:0]      MAXAL_W = SW'(MAXAL);
  localparam logic [SW-1:0]      STEP_W  = SW'(SHIFTSTEP);
  localparam logic [EXPBITS:0]   MAXAL_D = (EXPBITS + 1)'(MAXAL);
  localparam logic [EXPBITS-1:0] HIDX_E  = EXPBITS'(HIDX);
  localparam logic [EXPBITS-1:0] EXP_OVF = {{(EXPBITS - 1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ALIGN  = 3'd1,
    S_NORM   = 3'd2,
    S_SHR    = 3'd3,
    S_SHL    = 3'd4,
    S_ROUND  = 3'd5,
    S_RENORM = 3'd6,
    S_DONE   = 3'd7
  } state_t;

`ifdef FP_ADD_ROUND_EN
  localparam state_t S_POST = S_ROUND;
`else
  localparam state_t S_POST = S_DONE;
  logic unused_round_carry;
  assign unused_round_carry = RoundCarry;
`endif

  state_t         state, state_d;
  logic [SW-1:0]  cnt, cnt_d;
  logic           sel_b, sel_b_d;
  logic           clr_flags, set_ovf, set_unf, set_zero;

  logic [EXPBITS:0]   diff_ab, d_abs;
  logic               a_ge_b;
  logic [SW-1:0]      d_clamp;
  logic [EXPBITS-1:0] l_raw, l_lim;
  logic               l_under;
  logic [SW-1:0]      l_cnt;
  logic [SW-1:0]      step;

  assign diff_ab = {1'b0, ExpA} - {1'b0, ExpB};
  assign a_ge_b  = ~diff_ab[EXPBITS];
  assign d_abs   = a_ge_b ? diff_ab : -diff_ab;
  assign d_clamp = (d_abs > MAXAL_D) ? MAXAL_W : d_abs[SW-1:0];

  // Left distance is bounded so the exponent never goes below 1.
  assign l_raw   = HIDX_E - EXPBITS'(FFOIndex);
  assign l_lim   = (ExpCur == '0) ? '0 : ExpCur - 1'b1;
  assign l_under = l_raw > l_lim;
  assign l_cnt   = l_under ? l_lim[SW-1:0] : l_raw[SW-1:0];

  assign step = (cnt < STEP_W) ? cnt : STEP_W;

  assign AlignSelB = sel_b;
  assign StateDbg  = state;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      sel_b     <= 1'b0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
      Zero      <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      sel_b <= sel_b_d;
      if (clr_flags) begin
        Overflow  <= 1'b0;
        Underflow <= 1'b0;
        Zero      <= 1'b0;
      end else begin
        if (set_ovf)  Overflow  <= 1'b1;
        if (set_unf)  Underflow <= 1'b1;
        if (set_zero) Zero      <= 1'b1;
      end
    end
  end

  // Handshake: an operation starts on any edge where Go=1 and Ready=1; Ready is high only in
  // IDLE, and a Go seen while busy is dropped, never queued.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    sel_b_d     = sel_b;
    clr_flags   = 1'b0;
    set_ovf     = 1'b0;
    set_unf     = 1'b0;
    set_zero    = 1'b0;
    Ready       = 1'b0;
    Done        = 1'b0;
    AlignEn     = 1'b0;
    AlignAmt    = '0;
    SREn        = 1'b0;
    SLEn        = 1'b0;
    ShiftAmount = '0;
    IncrEn      = 1'b0;
    DecrEn      = 1'b0;
    RoundEn     = 1'b0;
    case (state)
      S_IDLE: begin
        Ready = 1'b1;
        if (Go) begin
          clr_flags = 1'b1;
          sel_b_d   = a_ge_b;
          cnt_d     = d_clamp;
          state_d   = (d_clamp != '0) ? S_ALIGN : S_NORM;
        end
      end
      S_ALIGN: begin
        AlignEn  = 1'b1;
        AlignAmt = step;
        cnt_d    = cnt - step;
        if (cnt == step) state_d = S_NORM;
      end
      S_NORM: begin
        if (!FFOValid) begin
          set_zero = 1'b1;
          state_d  = S_DONE;
        end else if (FFOIndex == CIDX_W) begin
          state_d = S_SHR;
        end else if (FFOIndex < HIDX_W) begin
          set_unf = l_under;
          cnt_d   = l_cnt;
          state_d = (l_cnt != '0) ? S_SHL : S_POST;
        end else begin
          state_d = S_POST;
        end
      end
      S_SHR: begin
        SREn   = 1'b1;
        IncrEn = 1'b1;
        if (ExpCur == EXP_OVF) begin
          set_ovf = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_POST;
        end
      end
      S_SHL: begin
        SLEn        = 1'b1;
        DecrEn      = 1'b1;
        ShiftAmount = step;
        cnt_d       = cnt - step;
        if (cnt == step) state_d = S_POST;
      end
`ifdef FP_ADD_ROUND_EN
      S_ROUND: begin
        RoundEn = 1'b1;
        state_d = RoundCarry ? S_RENORM : S_DONE;
      end
      S_RENORM: begin
        SREn    = 1'b1;
        IncrEn  = 1'b1;
        RoundEn = 1'b1;
        set_ovf = (ExpCur == EXP_OVF);
        state_d = S_DONE;
      end
`endif
      S_DONE: begin
        Done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fp_add_norm_sequencer.sv
// Bench for fp_add_norm_sequencer: directed and random operations against a trace-building model.
module tb_fp_add_norm_sequencer;

  localparam int STEP    = 8;
  localparam int MAXAL   = 25;
  localparam int HIDX    = 24;
  localparam int CIDX    = 25;
  localparam int EXP_OVF = 254;
  localparam int W       = 22;
`ifdef FP_ADD_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  // clock / reset
  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  logic       Go;
  logic [7:0] ExpA, ExpB, ExpCur;
  logic       FFOValid;
  logic [4:0] FFOIndex;
  logic       RoundCarry;
  logic       Ready, Done, AlignEn, AlignSelB, SREn, SLEn, IncrEn, DecrEn, RoundEn;
  logic [4:0] AlignAmt, ShiftAmount;
  logic       Overflow, Underflow, Zero;
  logic [2:0] state_dbg;

  fp_add_norm_sequencer dut (
    .Clock(Clock), .Reset(Reset), .Go(Go), .ExpA(ExpA), .ExpB(ExpB), .ExpCur(ExpCur),
    .FFOValid(FFOValid), .FFOIndex(FFOIndex), .RoundCarry(RoundCarry),
    .Ready(Ready), .Done(Done), .AlignEn(AlignEn), .AlignSelB(AlignSelB), .AlignAmt(AlignAmt),
    .SREn(SREn), .SLEn(SLEn), .ShiftAmount(ShiftAmount), .IncrEn(IncrEn), .DecrEn(DecrEn),
    .RoundEn(RoundEn), .Overflow(Overflow), .Underflow(Underflow), .Zero(Zero),
    .StateDbg(state_dbg)
  );

  // scoreboard: one expected output vector per clock cycle
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic m_sel, m_ovf, m_unf, m_zero;

  function automatic void push(input logic r, input logic d, input logic ae, input int aamt,
                               input logic sr, input logic sl, input int samt,
                               input logic inc, input logic dec, input logic rnd);
    exp_q.push_back({r, d, ae, m_sel, 5'(aamt), sr, sl, 5'(samt), inc, dec, rnd,
                     m_ovf, m_unf, m_zero});
  endfunction

  function automatic void model_reset();
    m_sel = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_zero = 1'b0;
  endfunction

  // Expected per-cycle trace of one operation, starting at the IDLE cycle that accepts Go.
  function automatic void model_op(input int a, input int b, input logic valid, input int idx,
                                   input int cur, input logic rc);
    int d, rem, amt, l, lim;
    bit to_post;
    push(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_ovf = 1'b0; m_unf = 1'b0; m_zero = 1'b0;
    m_sel = (a >= b);
    d = m_sel ? a - b : b - a;
    if (d > MAXAL) d = MAXAL;
    for (rem = d; rem > 0; rem -= amt) begin
      amt = (rem < STEP) ? rem : STEP;
      push(0, 0, 1, amt, 0, 0, 0, 0, 0, 0);
    end
    push(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    to_post = 1'b1;
    if (!valid) begin
      m_zero  = 1'b1;
      to_post = 1'b0;
    end else if (idx == CIDX) begin
      push(0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
      if (cur == EXP_OVF) begin
        m_ovf   = 1'b1;
        to_post = 1'b0;
      end
    end else if (idx < HIDX) begin
      l   = HIDX - idx;
      lim = (cur == 0) ? 0 : cur - 1;
      if (l > lim) begin
        l     = lim;
        m_unf = 1'b1;
      end
      for (rem = l; rem > 0; rem -= amt) begin
        amt = (rem < STEP) ? rem : STEP;
        push(0, 0, 0, 0, 0, 1, amt, 0, 1, 0);
      end
    end
    if (to_post && ROUND_EN) begin
      push(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      if (rc) begin
        push(0, 0, 0, 0, 1, 0, 0, 1, 0, 1);
        if (cur == EXP_OVF) m_ovf = 1'b1;
      end
    end
    push(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  // compare one cycle at the falling edge, then advance to just after the next rising edge
  task automatic check_cycle(input string tag, input int c);
    logic [W-1:0] obs, expv;
    @(negedge Clock);
    obs  = {Ready, Done, AlignEn, AlignSelB, AlignAmt, SREn, SLEn, ShiftAmount, IncrEn, DecrEn,
            RoundEn, Overflow, Underflow, Zero};
    expv = exp_q.pop_front();
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s cycle %0d state=%0d: observed %h required %h", tag, c, state_dbg, obs, expv);
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    Go = 1'b0;
    for (int i = 0; i < n; i++) begin
      push(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check_cycle("idle", i);
    end
  endtask

  // drivers
  task automatic run_op(input string tag, input int a, input int b, input logic valid,
                        input int idx, input int cur, input logic rc, input bit noise);
    int c;
    c = 0;
    model_op(a, b, valid, idx, cur, rc);
    ExpA = a[7:0]; ExpB = b[7:0]; FFOValid = valid; FFOIndex = idx[4:0];
    ExpCur = cur[7:0]; RoundCarry = rc; Go = 1'b1;
    while (exp_q.size() > 0) begin
      check_cycle(tag, c);
      c++;
      if (noise && exp_q.size() > 0) begin
        Go   = 1'($urandom_range(0, 1));
        ExpA = 8'($urandom_range(0, 255));
        ExpB = 8'($urandom_range(0, 255));
      end else begin
        Go = 1'b0;
      end
    end
    Go = 1'b0;
  endtask

  initial begin
    int a, b, idx, cur;
    logic valid, rc;
    Reset = 1'b1; Go = 1'b0; ExpA = '0; ExpB = '0; ExpCur = '0;
    FFOValid = 1'b0; FFOIndex = '0; RoundCarry = 1'b0;
    model_reset();
    @(posedge Clock);
    #1;
    push(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_cycle("reset", 0);
    Reset = 1'b0;
    idle_cycles(1);

    // reset in the middle of alignment
    model_op(160, 127, 1'b1, 24, 100, 1'b0);
    ExpA = 8'd160; ExpB = 8'd127; FFOValid = 1'b1; FFOIndex = 5'd24; ExpCur = 8'd100; Go = 1'b1;
    check_cycle("rst_mid", 0);
    Go = 1'b0;
    check_cycle("rst_mid", 1);
    Reset = 1'b1;
    check_cycle("rst_mid", 2);
    Reset = 1'b0;
    exp_q.delete();
    model_reset();
    push(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_cycle("rst_mid_idle", 3);

    // directed cases
    run_op("carry",     130, 127, 1'b1, 25, 130, 1'b0, 1'b0);
    run_op("large_d",   100, 130, 1'b1, 24, 100, 1'b0, 1'b0);
    run_op("left_norm", 100, 100, 1'b1, 10,  50, 1'b0, 1'b0);
    run_op("left_clamp",100, 100, 1'b1, 10,   5, 1'b0, 1'b0);
    run_op("overflow",  127, 127, 1'b1, 25, 254, 1'b1, 1'b0);
    run_op("zero",      127, 127, 1'b0,  0, 127, 1'b0, 1'b0);
    idle_cycles(2);
    run_op("min_lat",    90,  90, 1'b1, 24,  90, 1'b0, 1'b0);
    run_op("renorm",     90,  90, 1'b1, 24,  90, 1'b1, 1'b0);
    run_op("renorm_ovf", 90,  90, 1'b1, 24, 254, 1'b1, 1'b1);
    run_op("exp_one",    10,  10, 1'b1,  3,   1, 1'b0, 1'b1);

    // random operations, some back-to-back, some with Go noise while busy
    for (int i = 0; i < 60; i++) begin
      a     = $urandom_range(0, 255);
      b     = (i % 4 == 0) ? a + $urandom_range(0, 3) - 1 : $urandom_range(0, 255);
      if (b < 0) b = 0;
      if (b > 255) b = 255;
      valid = ($urandom_range(0, 5) != 0);
      idx   = $urandom_range(0, 25);
      case ($urandom_range(0, 3))
        0:       cur = EXP_OVF;
        1:       cur = $urandom_range(0, 6);
        default: cur = $urandom_range(0, 255);
      endcase
      rc = 1'($urandom_range(0, 1));
      run_op("rand", a, b, valid, idx, cur, rc, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
